// File: rtl/const_div_pipe.sv
// const_div_pipe: unsigned division by a compile-time constant using a
// reciprocal multiply followed by a single remainder correction step.
// The result is exact for every numerator in 0 .. 2^WIDTH-1.
//
// Three register stages:
//   S1  numerator * MUL_CONST (full-width product), numerator, valid
//   S2  q_est = product >> SHIFT_CONST, r_est = numerator - q_est*DIVISOR
//   S3  corrected quotient/remainder (q_est may be one below the true value)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   numerator offered this cycle
//   in_ready   block accepts the offered numerator this cycle
//   numerator  WIDTH-bit unsigned dividend
//   out_valid  quotient/remainder pair present
//   out_ready  consumer accepts the present pair
//   quotient   floor(numerator / DIVISOR)
//   remainder  numerator mod DIVISOR
module const_div_pipe #(
  parameter int unsigned     WIDTH       = 16,
  parameter longint unsigned DIVISOR     = 10,
  parameter int unsigned     SHIFT_CONST = WIDTH,
  // Floor of 2^SHIFT_CONST / DIVISOR; the guard only keeps elaboration
  // arithmetic defined when DIVISOR is illegally 0 (flagged below).
  parameter longint unsigned MUL_CONST   =
    (64'd1 << SHIFT_CONST) / ((DIVISOR == 0) ? 64'd1 : DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] numerator,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned     MW  = $clog2(MUL_CONST + 1);
  localparam int unsigned     PW  = WIDTH + MW;
  localparam logic [PW-1:0]   M_P = PW'(MUL_CONST);
  localparam logic [WIDTH:0]  D_W = (WIDTH+1)'(DIVISOR);

  if (DIVISOR == 0 || SHIFT_CONST < WIDTH) begin : g_bad_params
    $error("const_div_pipe: illegal parameters (DIVISOR must be >= 1 and SHIFT_CONST >= WIDTH)");
  end

  logic             w_advance;
  logic [PW-1:0]    w_prod;
  logic [WIDTH-1:0] w_q_est;
  logic [WIDTH:0]   w_r_est;
  logic             w_fix;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  logic             r_v1;
  logic [PW-1:0]    r_prod;
  logic [WIDTH-1:0] r_num1;
  logic             r_v2;
  logic [WIDTH-1:0] r_q2;
  logic [WIDTH:0]   r_r2;
  logic             r_v3;
  logic [WIDTH-1:0] r_q3;
  logic [WIDTH-1:0] r_r3;

  // The whole pipeline moves as one; a stalled output freezes every stage,
  // so bubbles keep their positions while stalled.
  assign w_advance = !r_v3 || out_ready;
  assign in_ready  = w_advance;

  always_comb begin
    w_prod  = {{MW{1'b0}}, numerator} * M_P;
    w_q_est = WIDTH'(r_prod >> SHIFT_CONST);
    // r_est lies in [0, 2*DIVISOR), hence the extra bit.
    w_r_est = {1'b0, r_num1} - ({1'b0, w_q_est} * D_W);
    w_fix   = (r_r2 >= D_W);
    w_q_fix = w_fix ? (r_q2 + 1'b1) : r_q2;
    w_r_fix = w_fix ? WIDTH'(r_r2 - D_W) : WIDTH'(r_r2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_prod <= '0;
      r_num1 <= '0;
      r_v2   <= 1'b0;
      r_q2   <= '0;
      r_r2   <= '0;
      r_v3   <= 1'b0;
      r_q3   <= '0;
      r_r3   <= '0;
    end else if (w_advance) begin
      r_v1   <= in_valid;
      r_prod <= w_prod;
      r_num1 <= numerator;
      r_v2   <= r_v1;
      r_q2   <= w_q_est;
      r_r2   <= w_r_est;
      r_v3   <= r_v2;
      r_q3   <= w_q_fix;
      r_r3   <= w_r_fix;
    end
  end

  assign out_valid = r_v3;
  assign quotient  = r_q3;
  assign remainder = r_r3;

endmodule

// File: tb/tb_const_div_pipe.sv
module tb_const_div_pipe;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance (WIDTH=16, DIVISOR=10)
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] numerator;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;

  const_div_pipe #(.WIDTH(16), .DIVISOR(10)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .numerator(numerator),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder)
  );

  // Parameter variants share one stimulus (truncated per width)
  logic        v_valid;
  logic [31:0] v_num;
  logic        v_ready;
  logic        a_ir, a_ov, b_ir, b_ov, c_ir, c_ov;
  logic [7:0]  a_q, a_r;
  logic [31:0] b_q, b_r;
  logic [15:0] c_q, c_r;

  const_div_pipe #(.WIDTH(8), .DIVISOR(3)) u_w8 (
    .clk(clk), .rst(rst),
    .in_valid(v_valid), .in_ready(a_ir), .numerator(v_num[7:0]),
    .out_valid(a_ov), .out_ready(v_ready), .quotient(a_q), .remainder(a_r)
  );
  const_div_pipe #(.WIDTH(32), .DIVISOR(7)) u_w32 (
    .clk(clk), .rst(rst),
    .in_valid(v_valid), .in_ready(b_ir), .numerator(v_num),
    .out_valid(b_ov), .out_ready(v_ready), .quotient(b_q), .remainder(b_r)
  );
  const_div_pipe #(.WIDTH(16), .DIVISOR(1)) u_d1 (
    .clk(clk), .rst(rst),
    .in_valid(v_valid), .in_ready(c_ir), .numerator(v_num[15:0]),
    .out_valid(c_ov), .out_ready(v_ready), .quotient(c_q), .remainder(c_r)
  );

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];
  exp_t sb8[$];
  exp_t sb32[$];
  exp_t sb1[$];

  // Called just after a falling edge with inputs already driven: records an
  // expected result on acceptance, samples outputs, then crosses the rising edge.
  task automatic tick(output bit ov, output bit ir, output bit cons,
                      output logic [15:0] oq, output logic [15:0] orr);
    exp_t e;
    #1;
    if (in_valid && in_ready) begin
      e.q = 32'(numerator) / 32'd10;
      e.r = 32'(numerator) % 32'd10;
      sb.push_back(e);
    end
    ov   = out_valid;
    ir   = in_ready;
    cons = out_valid && out_ready;
    oq   = quotient;
    orr  = remainder;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; numerator = '0;
    v_valid = 1'b0; v_num = '0; v_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
    checks++;
    if (quotient !== 16'd0 || remainder !== 16'd0) begin
      failures++; $display("FAIL reset_data got q=%0d r=%0d expected 0 0", quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_corners();
    bit ov, ir, cons; logic [15:0] oq, orr; exp_t e;
    logic [15:0] vals [4] = '{16'd65535, 16'd0, 16'd9, 16'd10};
    exp_t want [4];
    want[0] = '{32'd6553, 32'd5}; want[1] = '{32'd0, 32'd0};
    want[2] = '{32'd0, 32'd9};    want[3] = '{32'd1, 32'd0};
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid  = (k < 4);
      numerator = (k < 4) ? vals[k] : 16'd0;
      tick(ov, ir, cons, oq, orr);
      if (cons) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL corners_extra got q=%0d r=%0d expected none", oq, orr); end
        else begin
          e = sb.pop_front();
          if ({oq, orr} !== {e.q[15:0], e.r[15:0]}) begin
            failures++; $display("FAIL corners_data got q=%0d r=%0d expected q=%0d r=%0d", oq, orr, e.q, e.r);
          end
          checks++;
          if (k >= 3 && k < 7 && {oq, orr} !== {want[k-3].q[15:0], want[k-3].r[15:0]}) begin
            failures++; $display("FAIL corners_const got q=%0d r=%0d expected q=%0d r=%0d", oq, orr, want[k-3].q, want[k-3].r);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL corners_drain got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_sweep();
    bit ov, ir, cons; logic [15:0] oq, orr; exp_t e;
    out_ready = 1'b1;
    for (int k = 0; k < 65536 + 6; k++) begin
      in_valid  = (k < 65536);
      numerator = 16'(k);
      tick(ov, ir, cons, oq, orr);
      if (cons) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL sweep_extra got q=%0d r=%0d expected none", oq, orr); end
        else begin
          e = sb.pop_front();
          if ({oq, orr} !== {e.q[15:0], e.r[15:0]}) begin
            failures++; $display("FAIL sweep_data got q=%0d r=%0d expected q=%0d r=%0d", oq, orr, e.q, e.r);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sweep_drain got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    bit ov, ir, cons; logic [15:0] oq, orr; exp_t e;
    bit want_ov;
    out_ready = 1'b1;
    for (int k = 0; k < 26; k++) begin
      in_valid  = (k < 20);
      numerator = 16'(50 + k);
      tick(ov, ir, cons, oq, orr);
      // First accept is sample 0; results occupy samples 3..22.
      want_ov = (k >= 3 && k < 23);
      checks++;
      if (ov !== want_ov) begin failures++; $display("FAIL b2b_valid sample %0d got %b expected %b", k, ov, want_ov); end
      if (cons) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL b2b_extra got q=%0d r=%0d expected none", oq, orr); end
        else begin
          e = sb.pop_front();
          if ({oq, orr} !== {e.q[15:0], e.r[15:0]}) begin
            failures++; $display("FAIL b2b_data got q=%0d r=%0d expected q=%0d r=%0d", oq, orr, e.q, e.r);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ov, ir, cons; logic [15:0] oq, orr; exp_t e;
    logic [15:0] vals [3] = '{16'd1000, 16'd42, 16'd20};
    int got = 0;
    logic [15:0] want_q [3] = '{16'd100, 16'd4, 16'd2};
    logic [15:0] want_r [3] = '{16'd0, 16'd2, 16'd0};
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid  = (k < 3);
      numerator = (k < 3) ? vals[k] : 16'd7;
      tick(ov, ir, cons, oq, orr);
      if (k >= 3) begin
        checks++;
        if (ir !== 1'b0) begin failures++; $display("FAIL bp_in_ready got %b expected 0", ir); end
        checks++;
        if (ov !== 1'b1 || oq !== 16'd100 || orr !== 16'd0) begin
          failures++; $display("FAIL bp_hold got v=%b q=%0d r=%0d expected v=1 q=100 r=0", ov, oq, orr);
        end
      end
    end
    out_ready = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick(ov, ir, cons, oq, orr);
      if (cons) begin
        checks++;
        if (sb.size() == 0 || got >= 3) begin failures++; $display("FAIL bp_extra got q=%0d r=%0d expected none", oq, orr); end
        else begin
          e = sb.pop_front();
          if ({oq, orr} !== {e.q[15:0], e.r[15:0]} || oq !== want_q[got] || orr !== want_r[got]) begin
            failures++; $display("FAIL bp_data got q=%0d r=%0d expected q=%0d r=%0d", oq, orr, want_q[got], want_r[got]);
          end
          got++;
        end
      end
    end
    checks++;
    if (got != 3) begin failures++; $display("FAIL bp_count got %0d expected 3", got); end
  endtask

  task automatic test_random_stall();
    bit ov, ir, cons; logic [15:0] oq, orr; exp_t e;
    bit prev_stall = 1'b0;
    logic [15:0] pq = '0, pr = '0;
    for (int k = 0; k < 406; k++) begin
      in_valid  = (k < 400) && ($urandom_range(0, 2) != 0);
      out_ready = (k >= 400) || ($urandom_range(0, 2) != 0);
      numerator = 16'($urandom);
      tick(ov, ir, cons, oq, orr);
      checks++;
      if (ir !== (!ov || out_ready)) begin
        failures++; $display("FAIL stall_in_ready got %b expected %b", ir, !ov || out_ready);
      end
      if (prev_stall) begin
        checks++;
        if (ov !== 1'b1 || oq !== pq || orr !== pr) begin
          failures++; $display("FAIL stall_hold got v=%b q=%0d r=%0d expected v=1 q=%0d r=%0d", ov, oq, orr, pq, pr);
        end
      end
      prev_stall = ov && !out_ready;
      pq = oq; pr = orr;
      if (cons) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL stall_extra got q=%0d r=%0d expected none", oq, orr); end
        else begin
          e = sb.pop_front();
          if ({oq, orr} !== {e.q[15:0], e.r[15:0]}) begin
            failures++; $display("FAIL stall_data got q=%0d r=%0d expected q=%0d r=%0d", oq, orr, e.q, e.r);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL stall_drain got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    bit ov, ir, cons; logic [15:0] oq, orr; exp_t e;
    int got = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid  = (k < 2);
      numerator = (k == 0) ? 16'd1234 : 16'd5678;
      tick(ov, ir, cons, oq, orr);
    end
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre got %b expected 1", out_valid); end
    // Assert between edges: valid must drop without a clock edge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_async got v=%b ir=%b expected v=0 ir=1", out_valid, in_ready);
    end
    sb.delete();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; numerator = 16'd77;
    for (int k = 0; k < 8; k++) begin
      tick(ov, ir, cons, oq, orr);
      if (k == 0) begin
        checks++;
        if (ir !== 1'b1) begin failures++; $display("FAIL rstmid_first_accept got %b expected 1", ir); end
      end
      in_valid = 1'b0;
      if (cons) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL rstmid_stale got q=%0d r=%0d expected none", oq, orr); end
        else begin
          e = sb.pop_front();
          if (oq !== 16'd7 || orr !== 16'd7 || {oq, orr} !== {e.q[15:0], e.r[15:0]}) begin
            failures++; $display("FAIL rstmid_data got q=%0d r=%0d expected q=7 r=7", oq, orr);
          end
          got++;
        end
      end
    end
    checks++;
    if (got != 1) begin failures++; $display("FAIL rstmid_count got %0d expected 1", got); end
  endtask

  task automatic test_variants();
    exp_t e;
    logic [31:0] corner [6] = '{32'hFFFF_FFFF, 32'd0, 32'd2, 32'd6, 32'd65535, 32'd255};
    v_ready = 1'b1;
    for (int k = 0; k < 2010; k++) begin
      v_valid = (k < 2000);
      v_num   = (k < 6) ? corner[k] : $urandom;
      #1;
      if (v_valid && a_ir) begin e.q = 32'(v_num[7:0]) / 32'd3; e.r = 32'(v_num[7:0]) % 32'd3; sb8.push_back(e); end
      if (v_valid && b_ir) begin
        e.q = 32'(64'(v_num) / 64'd7); e.r = 32'(64'(v_num) % 64'd7); sb32.push_back(e);
      end
      if (v_valid && c_ir) begin e.q = 32'(v_num[15:0]); e.r = 32'd0; sb1.push_back(e); end
      if (a_ov) begin
        checks++;
        if (sb8.size() == 0) begin failures++; $display("FAIL w8_extra got q=%0d expected none", a_q); end
        else begin
          e = sb8.pop_front();
          if ({a_q, a_r} !== {e.q[7:0], e.r[7:0]}) begin
            failures++; $display("FAIL w8_data got q=%0d r=%0d expected q=%0d r=%0d", a_q, a_r, e.q, e.r);
          end
        end
      end
      if (b_ov) begin
        checks++;
        if (sb32.size() == 0) begin failures++; $display("FAIL w32_extra got q=%0d expected none", b_q); end
        else begin
          e = sb32.pop_front();
          if ({b_q, b_r} !== {e.q, e.r}) begin
            failures++; $display("FAIL w32_data got q=%0d r=%0d expected q=%0d r=%0d", b_q, b_r, e.q, e.r);
          end
          if (k == 3) begin
            checks++;
            if (b_q !== 32'd613566756 || b_r !== 32'd3) begin
              failures++; $display("FAIL w32_max got q=%0d r=%0d expected q=613566756 r=3", b_q, b_r);
            end
          end
        end
      end
      if (c_ov) begin
        checks++;
        if (sb1.size() == 0) begin failures++; $display("FAIL d1_extra got q=%0d expected none", c_q); end
        else begin
          e = sb1.pop_front();
          if ({c_q, c_r} !== {e.q[15:0], e.r[15:0]}) begin
            failures++; $display("FAIL d1_data got q=%0d r=%0d expected q=%0d r=%0d", c_q, c_r, e.q, e.r);
          end
        end
      end
      if (k == 3) begin
        checks++;
        if (a_q !== 8'd85 || a_r !== 8'd0 || c_q !== 16'd65535 || c_r !== 16'd0) begin
          failures++; $display("FAIL var_max got w8 q=%0d r=%0d d1 q=%0d r=%0d expected 85 0 65535 0", a_q, a_r, c_q, c_r);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (sb8.size() != 0 || sb32.size() != 0 || sb1.size() != 0) begin
      failures++; $display("FAIL var_drain got %0d/%0d/%0d pending expected 0", sb8.size(), sb32.size(), sb1.size());
    end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_reset_mid();
    test_sweep();
    test_variants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
